sha256_round_ctrl: RTL and testbench
====================================

# sha256_round_ctrl

Sequencing controller for the SHA-256 compression datapath. It owns the 8×32-bit intermediate hash state H and loads it with the FIPS 180-4 IV or chains it from the previous block. It drives the datapath's load/enable strobes and round index through 64 rounds, then folds the working variables back into H. It sits between the host/padding front end, which supplies a ready message schedule W and a START pulse, and the compression datapath, whose H input it feeds.

## Interface
- ROUNDS, 64: rounds per block; fixed at 64 for SHA-256, parameterised only for reduced-round bench runs.
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request to hash one 512-bit block; sampled only in IDLE.
- FIRST_BLOCK  in  1  sampled with START; 1 = load IV into H before the block.
- ABORT  in  1  cancel the current block; return to IDLE.
- a, b, c, d, e, f, g, h  in  32 each  working variables returned from the datapath.
- H  out  32×8  intermediate/final hash state; drives datapath H input.
- SET_COMPRESSION  out  1  datapath load strobe (a..h ← H).
- COMPRESSION_EN  out  1  datapath round-enable strobe.
- i  out  6  round index for K[i]/W[i] selection.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse; H holds the updated digest.
- BLOCK_COUNT  out  32  number of blocks completed since the last FIRST_BLOCK start.

## Operation
- States: IDLE, LOAD, ROUND, UPDATE, DONE.
  - Transitions: IDLE→LOAD on START; LOAD→ROUND unconditionally; ROUND→UPDATE when i = ROUNDS−1; UPDATE→DONE; DONE→IDLE.
- IDLE:
  - Strobes low, i = 0.
  - On START with FIRST_BLOCK=1: H ← IV at the same edge, and BLOCK_COUNT ← 0.
  - IV = 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
  - FIRST_BLOCK=0 keeps H as chained state.
- LOAD: SET_COMPRESSION=1 for exactly one cycle, i = 0.
- ROUND:
  - COMPRESSION_EN=1 every cycle.
  - i = 0 in the first ROUND cycle and increments by 1 each cycle.
  - i is stable for the whole cycle, because the datapath samples K[i]/W[i] on negedge.
- UPDATE: strobes low. At the edge ending this state, H[k] ← H[k] + {a..h}[k] mod 2^32, with carries discarded.
- DONE:
  - DONE=1 for one cycle.
  - BLOCK_COUNT increments (wraps at 2^32) at the edge entering DONE.
- SET_COMPRESSION and COMPRESSION_EN are never high in the same cycle.
- All outputs are decoded from registered state/counters only; there is no combinational input→output path.
- i is 0 in every state except ROUND.
- START outside IDLE is ignored; no queuing.
- ABORT:
  - Any non-IDLE state → IDLE at the next edge.
  - H and BLOCK_COUNT are unchanged, and DONE is not pulsed.
  - ABORT during UPDATE suppresses the H write.
  - ABORT and START together in IDLE: ABORT wins, stay IDLE, no IV load.
- RESET (any time, including mid-block): state IDLE, H = IV, i = 0, BLOCK_COUNT = 0, every strobe/BUSY/DONE = 0.

## Timing
- START sampled at edge 0 → LOAD in cycle 1 → ROUND in cycles 2..65 (i = 0..63) → UPDATE in cycle 66 → DONE=1 in cycle 67 → IDLE in cycle 68.
- START-to-DONE latency: 67 cycles. Minimum START-to-START spacing: 68 cycles.
- BUSY rises in cycle 1 and falls in cycle 68.
- H is valid from cycle 67 until the next UPDATE or IV load.
- W must be valid and stable from cycle 2 through cycle 65. The front end must not change W while BUSY=1.

## Test plan
- Reset: assert RESET mid-ROUND (i=30) → same cycle asynchronously: H = IV, i = 0, BUSY = 0, COMPRESSION_EN = 0; after release, START works normally.
- Single block "abc" (FIRST_BLOCK=1) → DONE in cycle 67 with H = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, BLOCK_COUNT = 1.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (second START with FIRST_BLOCK=0) → H = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, BLOCK_COUNT = 2.
- Strobe check: exactly 1 SET_COMPRESSION cycle, then exactly 64 consecutive COMPRESSION_EN cycles with i = 0..63, with no overlap.
- ABORT in UPDATE cycle → no DONE, H equals its pre-block value, IDLE next cycle. START pulses during BUSY → ignored, DONE count stays 1.
- ABORT+START simultaneous in IDLE with FIRST_BLOCK=1 after the "abc" block → stays IDLE, H keeps the "abc" digest.

Source files
------------

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: owns the 8x32 hash state H and steps the
// external round datapath through LOAD, ROUNDS x ROUND, UPDATE and DONE.
module sha256_round_ctrl #(
   parameter int ROUNDS = 64
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic              FIRST_BLOCK,
   input  logic              ABORT,
   input  logic [31:0]       a,
   input  logic [31:0]       b,
   input  logic [31:0]       c,
   input  logic [31:0]       d,
   input  logic [31:0]       e,
   input  logic [31:0]       f,
   input  logic [31:0]       g,
   input  logic [31:0]       h,
   output logic [7:0][31:0]  H,
   output logic              SET_COMPRESSION,
   output logic              COMPRESSION_EN,
   output logic [5:0]        i,
   output logic              BUSY,
   output logic              DONE,
   output logic [31:0]       BLOCK_COUNT
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ROUND,
      S_UPDATE,
      S_DONE
   } state_t;

   // Word 0 of H is the first word of the digest.
   localparam logic [7:0][31:0] IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

   state_t           state;
   logic [7:0][31:0] work;

   assign work = {h, g, f, e, d, c, b, a};

   // NOTE: every register here, including the eight H words, is assigned with <=
   // so all state updates on an edge see the pre-edge values of each other.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state           <= S_IDLE;
         // NOTE: H is a small register file, not RAM, so it resets to the IV
         // like any other register.
         H               <= IV;
         i               <= '0;
         BLOCK_COUNT     <= '0;
         SET_COMPRESSION <= 1'b0;
         COMPRESSION_EN  <= 1'b0;
         BUSY            <= 1'b0;
         DONE            <= 1'b0;
      end else begin
         SET_COMPRESSION <= 1'b0;
         COMPRESSION_EN  <= 1'b0;
         DONE            <= 1'b0;
         i               <= '0;
         if (ABORT) begin
            // Abort beats START in IDLE and suppresses the H write in UPDATE.
            state <= S_IDLE;
            BUSY  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (START) begin
                     state           <= S_LOAD;
                     SET_COMPRESSION <= 1'b1;
                     BUSY            <= 1'b1;
                     if (FIRST_BLOCK) begin
                        H           <= IV;
                        BLOCK_COUNT <= '0;
                     end
                  end
               end
               S_LOAD: begin
                  state          <= S_ROUND;
                  COMPRESSION_EN <= 1'b1;
               end
               S_ROUND: begin
                  if (i == LAST_ROUND) begin
                     state <= S_UPDATE;
                  end else begin
                     COMPRESSION_EN <= 1'b1;
                     i              <= i + 6'd1;
                  end
               end
               S_UPDATE: begin
                  state       <= S_DONE;
                  DONE        <= 1'b1;
                  BLOCK_COUNT <= BLOCK_COUNT + 32'd1;
                  for (int k = 0; k < 8; k++) begin
                     H[k] <= H[k] + work[k];
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl with a behavioural round datapath and
// message schedule, checked against known FIPS 180-4 digests.
module tb_sha256_round_ctrl;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             START;
   logic             FIRST_BLOCK;
   logic             ABORT;
   logic [31:0]      da = '0, db = '0, dc = '0, dd = '0;
   logic [31:0]      de = '0, df = '0, dg = '0, dh = '0;
   logic [7:0][31:0] H;
   logic             SET_COMPRESSION;
   logic             COMPRESSION_EN;
   logic [5:0]       i;
   logic             BUSY;
   logic             DONE;
   logic [31:0]      BLOCK_COUNT;

   int n_pass = 0;
   int n_total = 0;

   sha256_round_ctrl #(.ROUNDS(64)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .FIRST_BLOCK(FIRST_BLOCK),
      .ABORT(ABORT),
      .a(da), .b(db), .c(dc), .d(dd), .e(de), .f(df), .g(dg), .h(dh),
      .H(H), .SET_COMPRESSION(SET_COMPRESSION), .COMPRESSION_EN(COMPRESSION_EN),
      .i(i), .BUSY(BUSY), .DONE(DONE), .BLOCK_COUNT(BLOCK_COUNT)
   );

   always #5 CLK = ~CLK;

   localparam logic [7:0][31:0] IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };
   localparam logic [7:0][31:0] DIG_ABC = {
      32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
      32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf
   };
   localparam logic [7:0][31:0] DIG_TWO = {
      32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
      32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61
   };

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic [31:0] blk_abc [16] = '{
      32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018
   };
   logic [31:0] blk_two1 [16] = '{
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
   };
   logic [31:0] blk_two2 [16] = '{
      32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0
   };

   logic [31:0] W [64];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Datapath model: loads a..h from H on SET_COMPRESSION, runs round i on COMPRESSION_EN.
   always @(posedge CLK) begin : datapath
      logic [31:0] t1, t2;
      if (SET_COMPRESSION) begin
         da <= H[0]; db <= H[1]; dc <= H[2]; dd <= H[3];
         de <= H[4]; df <= H[5]; dg <= H[6]; dh <= H[7];
      end else if (COMPRESSION_EN) begin
         t1 = dh + (rotr(de, 6) ^ rotr(de, 11) ^ rotr(de, 25))
                 + ((de & df) ^ (~de & dg)) + K[i] + W[i];
         t2 = (rotr(da, 2) ^ rotr(da, 13) ^ rotr(da, 22))
                 + ((da & db) ^ (da & dc) ^ (db & dc));
         dh <= dg; dg <= df; df <= de; de <= dd + t1;
         dd <= dc; dc <= db; db <= da; da <= t1 + t2;
      end
   end

   typedef struct {
      int n_set;
      int n_en;
      int n_done;
      int done_cycle;
      bit seq_ok;
      bit busy_ok;
   } obs_t;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_schedule(input logic [31:0] blk [16]);
      for (int t = 0; t < 64; t++) begin
         if (t < 16) W[t] = blk[t];
         else W[t] = (rotr(W[t-2], 17) ^ rotr(W[t-2], 19) ^ (W[t-2] >> 10)) + W[t-7]
                   + (rotr(W[t-15], 7) ^ rotr(W[t-15], 18) ^ (W[t-15] >> 3)) + W[t-16];
      end
   endtask

   // Runs one block from START through cycle 68, pulsing a stray START (with
   // FIRST_BLOCK=1) at the given cycles, and records what the strobes did.
   task automatic run_block(input logic [31:0] blk [16], input logic fb,
                            input int pulse_a, input int pulse_b, output obs_t o);
      o = '{n_set: 0, n_en: 0, n_done: 0, done_cycle: -1, seq_ok: 1'b1, busy_ok: 1'b1};
      load_schedule(blk);
      FIRST_BLOCK = fb;
      START = 1'b1;
      tick();
      START = 1'b0;
      FIRST_BLOCK = 1'b0;
      for (int cyc = 1; cyc <= 68; cyc++) begin
         if (SET_COMPRESSION === 1'b1) begin
            o.n_set++;
            if (cyc != 1) o.seq_ok = 1'b0;
         end
         if (COMPRESSION_EN === 1'b1) begin
            o.n_en++;
            if (cyc < 2 || cyc > 65 || i !== 6'(cyc - 2)) o.seq_ok = 1'b0;
         end else if (i !== 6'd0) begin
            o.seq_ok = 1'b0;
         end
         if (SET_COMPRESSION === 1'b1 && COMPRESSION_EN === 1'b1) o.seq_ok = 1'b0;
         if (DONE === 1'b1) begin
            o.n_done++;
            o.done_cycle = cyc;
         end
         if (BUSY !== (cyc <= 67)) o.busy_ok = 1'b0;
         if (cyc == pulse_a || cyc == pulse_b) begin
            START = 1'b1;
            FIRST_BLOCK = 1'b1;
         end
         tick();
         START = 1'b0;
         FIRST_BLOCK = 1'b0;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1; START = 1'b0; FIRST_BLOCK = 1'b0; ABORT = 1'b0;
      repeat (2) tick();
      RESET = 1'b0;
      tick();
      n_total++;
      if (H !== IV) $display("FAIL reset_h got %h want %h", H, IV); else n_pass++;
      n_total++;
      if ({BUSY, DONE, SET_COMPRESSION, COMPRESSION_EN} !== 4'b0)
         $display("FAIL reset_strobes got %b want 0000", {BUSY, DONE, SET_COMPRESSION, COMPRESSION_EN});
      else n_pass++;
      n_total++;
      if (i !== 6'd0 || BLOCK_COUNT !== 32'd0)
         $display("FAIL reset_counters got i=%0d cnt=%0d want 0/0", i, BLOCK_COUNT);
      else n_pass++;
   endtask

   task automatic test_abc();
      obs_t o;
      run_block(blk_abc, 1'b1, 10, 67, o);
      n_total++;
      if (o.n_set !== 1) $display("FAIL abc_set_count got %0d want 1", o.n_set); else n_pass++;
      n_total++;
      if (o.n_en !== 64) $display("FAIL abc_en_count got %0d want 64", o.n_en); else n_pass++;
      n_total++;
      if (o.seq_ok !== 1'b1) $display("FAIL abc_strobe_seq got %b want 1", o.seq_ok); else n_pass++;
      n_total++;
      if (o.done_cycle !== 67) $display("FAIL abc_done_cycle got %0d want 67", o.done_cycle); else n_pass++;
      n_total++;
      if (o.n_done !== 1) $display("FAIL abc_done_count got %0d want 1", o.n_done); else n_pass++;
      n_total++;
      if (o.busy_ok !== 1'b1) $display("FAIL abc_busy got %b want 1", o.busy_ok); else n_pass++;
      n_total++;
      if (H !== DIG_ABC) $display("FAIL abc_digest got %h want %h", H, DIG_ABC); else n_pass++;
      n_total++;
      if (BLOCK_COUNT !== 32'd1) $display("FAIL abc_block_count got %0d want 1", BLOCK_COUNT); else n_pass++;
   endtask

   task automatic test_abort_start_idle();
      START = 1'b1; FIRST_BLOCK = 1'b1; ABORT = 1'b1;
      tick();
      START = 1'b0; FIRST_BLOCK = 1'b0; ABORT = 1'b0;
      n_total++;
      if (BUSY !== 1'b0 || SET_COMPRESSION !== 1'b0)
         $display("FAIL abort_start_idle got busy=%b set=%b want 0/0", BUSY, SET_COMPRESSION);
      else n_pass++;
      n_total++;
      if (H !== DIG_ABC) $display("FAIL abort_start_h got %h want %h", H, DIG_ABC); else n_pass++;
      n_total++;
      if (BLOCK_COUNT !== 32'd1) $display("FAIL abort_start_cnt got %0d want 1", BLOCK_COUNT); else n_pass++;
   endtask

   task automatic test_abort_update();
      int dones = 0;
      load_schedule(blk_abc);
      START = 1'b1; FIRST_BLOCK = 1'b0;
      tick();
      START = 1'b0;
      repeat (65) tick();
      n_total++;
      if (BUSY !== 1'b1 || COMPRESSION_EN !== 1'b0 || DONE !== 1'b0 || i !== 6'd0)
         $display("FAIL abort_upd_at_update got busy=%b en=%b done=%b i=%0d want 1/0/0/0",
                  BUSY, COMPRESSION_EN, DONE, i);
      else n_pass++;
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      n_total++;
      if (BUSY !== 1'b0 || DONE !== 1'b0)
         $display("FAIL abort_upd_idle got busy=%b done=%b want 0/0", BUSY, DONE);
      else n_pass++;
      n_total++;
      if (H !== DIG_ABC) $display("FAIL abort_upd_h got %h want %h", H, DIG_ABC); else n_pass++;
      n_total++;
      if (BLOCK_COUNT !== 32'd1) $display("FAIL abort_upd_cnt got %0d want 1", BLOCK_COUNT); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         if (DONE === 1'b1) dones++;
         tick();
      end
      n_total++;
      if (dones !== 0) $display("FAIL abort_upd_no_done got %0d want 0", dones); else n_pass++;
   endtask

   task automatic test_two_block();
      obs_t o;
      run_block(blk_two1, 1'b1, 0, 0, o);
      n_total++;
      if (o.done_cycle !== 67 || BLOCK_COUNT !== 32'd1)
         $display("FAIL two_first got done=%0d cnt=%0d want 67/1", o.done_cycle, BLOCK_COUNT);
      else n_pass++;
      run_block(blk_two2, 1'b0, 0, 0, o);
      n_total++;
      if (o.seq_ok !== 1'b1 || o.n_done !== 1)
         $display("FAIL two_second_seq got seq=%b dones=%0d want 1/1", o.seq_ok, o.n_done);
      else n_pass++;
      n_total++;
      if (H !== DIG_TWO) $display("FAIL two_digest got %h want %h", H, DIG_TWO); else n_pass++;
      n_total++;
      if (BLOCK_COUNT !== 32'd2) $display("FAIL two_block_count got %0d want 2", BLOCK_COUNT); else n_pass++;
   endtask

   task automatic test_reset_mid_round();
      obs_t o;
      int   budget = 0;
      load_schedule(blk_abc);
      START = 1'b1; FIRST_BLOCK = 1'b1;
      tick();
      START = 1'b0; FIRST_BLOCK = 1'b0;
      while (i !== 6'd30 && budget < 100) begin
         tick();
         budget++;
      end
      n_total++;
      if (i !== 6'd30) $display("FAIL rst_mid_reach got i=%0d want 30", i); else n_pass++;
      #2 RESET = 1'b1;
      #1;
      n_total++;
      if (H !== IV) $display("FAIL rst_mid_h got %h want %h", H, IV); else n_pass++;
      n_total++;
      if (i !== 6'd0 || BUSY !== 1'b0 || COMPRESSION_EN !== 1'b0 || BLOCK_COUNT !== 32'd0)
         $display("FAIL rst_mid_ctrl got i=%0d busy=%b en=%b cnt=%0d want 0/0/0/0",
                  i, BUSY, COMPRESSION_EN, BLOCK_COUNT);
      else n_pass++;
      tick();
      RESET = 1'b0;
      tick();
      run_block(blk_abc, 1'b1, 0, 0, o);
      n_total++;
      if (H !== DIG_ABC || o.done_cycle !== 67 || BLOCK_COUNT !== 32'd1)
         $display("FAIL rst_mid_restart got h=%h done=%0d cnt=%0d want %h/67/1",
                  H, o.done_cycle, BLOCK_COUNT, DIG_ABC);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_abc();
      test_abort_start_idle();
      test_abort_update();
      test_two_block();
      test_reset_mid_round();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
